// File: rtl/cu_wb_arbiter.sv
// Register-file write-back arbiter: four source FIFOs, bc strict priority,
// round-robin among ALU/MUL/SHF, stall, overflow and RAW hazard flags.
module cu_wb_arbiter #(
  parameter int RF_DATASIZE   = 40,
  parameter int ADDRESS_WIDTH = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_exe,
  input  logic                     reset,
  input  logic                     alu_wb_req,
  input  logic [ADDRESS_WIDTH-1:0] alu_wb_add,
  input  logic [RF_DATASIZE-1:0]   alu_wb_dt,
  input  logic                     mul_wb_req,
  input  logic [ADDRESS_WIDTH-1:0] mul_wb_add,
  input  logic [RF_DATASIZE-1:0]   mul_wb_dt,
  input  logic                     shf_wb_req,
  input  logic [ADDRESS_WIDTH-1:0] shf_wb_add,
  input  logic [RF_DATASIZE-1:0]   shf_wb_dt,
  input  logic                     bc_wb_req,
  input  logic [ADDRESS_WIDTH-1:0] bc_wb_add,
  input  logic [RF_DATASIZE-1:0]   bc_wb_dt,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
  input  logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
  output logic                     wb_rf_w_en,
  output logic [ADDRESS_WIDTH-1:0] wb_rf_add,
  output logic [RF_DATASIZE-1:0]   wb_rf_dt,
  output logic                     wb_ps_stall,
  output logic                     wb_ps_raw,
  output logic                     wb_ps_ovf
);

  localparam int NS = 4;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = ADDRESS_WIDTH + RF_DATASIZE;
  localparam logic [PW:0] FULL_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] HI_C   = (PW+1)'(FIFO_DEPTH - 1);
  localparam logic [1:0]  BC     = 2'd3;

  logic [NS-1:0] req;
  logic [EW-1:0] din  [NS];
  logic [EW-1:0] head [NS];
  logic [EW-1:0] mem  [NS][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr [NS];
  logic [PW-1:0] wr_ptr [NS];
  logic [PW:0]   cnt    [NS];

  logic [NS-1:0] nempty, pop, push_ok, drop, hi;
  logic [1:0]    last, c0, c1, c2;
  logic          gnt_v;
  logic [1:0]    gnt_idx;

  assign req     = {bc_wb_req, shf_wb_req, mul_wb_req, alu_wb_req};
  assign din[0]  = {alu_wb_add, alu_wb_dt};
  assign din[1]  = {mul_wb_add, mul_wb_dt};
  assign din[2]  = {shf_wb_add, shf_wb_dt};
  assign din[3]  = {bc_wb_add, bc_wb_dt};

  function automatic logic [1:0] rr_next(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign c0 = rr_next(last);
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = BC;
    if (nempty[BC]) begin
      gnt_v   = 1'b1;
      gnt_idx = BC;
    end else if (nempty[c0]) begin
      gnt_v   = 1'b1;
      gnt_idx = c0;
    end else if (nempty[c1]) begin
      gnt_v   = 1'b1;
      gnt_idx = c1;
    end else if (nempty[c2]) begin
      gnt_v   = 1'b1;
      gnt_idx = c2;
    end
  end

  // a full FIFO still accepts a push when its head leaves on the same edge
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      head[i]    = mem[i][rd_ptr[i]];
      nempty[i]  = (cnt[i] != '0);
      hi[i]      = (cnt[i] >= HI_C);
      pop[i]     = gnt_v && (gnt_idx == 2'(i));
      push_ok[i] = req[i] && ((cnt[i] < FULL_C) || pop[i]);
      drop[i]    = req[i] && !push_ok[i];
    end
  end

  always_ff @(posedge clk_exe) begin
    for (int i = 0; i < NS; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= din[i];
    end
  end

  always_ff @(posedge clk_exe) begin
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (PW+1)'(push_ok[i]) - (PW+1)'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk_exe) begin
    if (reset) begin
      wb_rf_w_en  <= 1'b0;
      wb_rf_add   <= '0;
      wb_rf_dt    <= '0;
      wb_ps_stall <= 1'b0;
      wb_ps_ovf   <= 1'b0;
      last        <= 2'd2;
    end else begin
      wb_rf_w_en  <= gnt_v;
      wb_ps_stall <= |hi;
      if (gnt_v) {wb_rf_add, wb_rf_dt} <= head[gnt_idx];
      if (gnt_v && gnt_idx != BC) last <= gnt_idx;
      if (|drop) wb_ps_ovf <= 1'b1;
    end
  end

  // slot j is live when its distance from the read pointer is below count
  always_comb begin
    logic [PW-1:0]            off;
    logic [ADDRESS_WIDTH-1:0] a;
    off = '0;
    a   = '0;
    wb_ps_raw = wb_rf_w_en &&
                (wb_rf_add == ps_xb_raddx || wb_rf_add == ps_xb_raddy);
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        off = PW'(j) - rd_ptr[i];
        a   = mem[i][j][EW-1 -: ADDRESS_WIDTH];
        if ({1'b0, off} < cnt[i] &&
            (a == ps_xb_raddx || a == ps_xb_raddy))
          wb_ps_raw = 1'b1;
      end
    end
  end

endmodule
